// File: rtl/pulse_envelope_pkg.sv
// -----------------------------------------------------------------------------
// pulse_envelope_pkg
// Shared types and helpers for the pulse-channel ADSR envelope controller:
//   - ADSR state encoding (IDLE..RELEASE, values 0..4; 5..7 are illegal)
//   - level / rate widths and their typedefs
//   - saturating add / subtract used by the level datapath
// -----------------------------------------------------------------------------
package pulse_envelope_pkg;

  localparam int ENV_LEVEL_W = 9;
  localparam int ENV_RATE_W  = 8;
  localparam int ENV_STATE_W = 3;

  typedef logic [ENV_LEVEL_W-1:0] env_level_t;
  typedef logic [ENV_RATE_W-1:0]  env_rate_t;

  typedef enum logic [ENV_STATE_W-1:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_e;

  // min(level + rate, ceiling). The extra MSB keeps the carry so a sum
  // that overflows 9 bits still saturates instead of wrapping.
  function automatic env_level_t sat_add(input env_level_t level,
                                         input env_rate_t  rate,
                                         input env_level_t ceiling);
    logic [ENV_LEVEL_W:0] sum;
    sum = {1'b0, level} + {{(ENV_LEVEL_W - ENV_RATE_W + 1){1'b0}}, rate};
    if (sum >= {1'b0, ceiling}) return ceiling;
    return sum[ENV_LEVEL_W-1:0];
  endfunction

  // max(level - rate, floor). The extra MSB acts as the borrow flag, so an
  // underflow below zero also lands on the floor.
  function automatic env_level_t sat_sub(input env_level_t level,
                                         input env_rate_t  rate,
                                         input env_level_t floor);
    logic [ENV_LEVEL_W:0] diff;
    diff = {1'b0, level} - {{(ENV_LEVEL_W - ENV_RATE_W + 1){1'b0}}, rate};
    if (diff[ENV_LEVEL_W] || (diff[ENV_LEVEL_W-1:0] < floor)) return floor;
    return diff[ENV_LEVEL_W-1:0];
  endfunction

endpackage : pulse_envelope_pkg

// File: rtl/envelope_tick_prescaler.sv
// -----------------------------------------------------------------------------
// envelope_tick_prescaler
// Divides the global tick strobe down to the envelope step strobe: every
// TICK_DIV-th tick produces a one-cycle step. A restart (note-on) clears the
// count so the first step of a note lands exactly TICK_DIV ticks later; a tick
// arriving in the restart cycle is not counted.
//
// Parameters:
//   TICK_DIV    ticks per envelope step, 1..255
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_tick_stb  one-cycle time-base strobe
//   i_restart   clear the tick count (note-on)
//   o_step_stb  one-cycle envelope step strobe (combinational from count)
// -----------------------------------------------------------------------------
module envelope_tick_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick_stb,
  input  logic i_restart,
  output logic o_step_stb
);

  localparam logic [7:0] TERMINAL = 8'(TICK_DIV - 1);

  logic [7:0] count;
  logic       at_terminal;

  assign at_terminal = (count == TERMINAL);

  // The step is decoded from the current count so the FSM sees it in the
  // same cycle as the tick; the level update then appears one cycle later.
  assign o_step_stb = i_tick_stb & ~i_restart & at_terminal;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_restart) begin
      count <= '0;
    end else if (i_tick_stb) begin
      count <= at_terminal ? 8'd0 : count + 8'd1;
    end
  end

endmodule : envelope_tick_prescaler

// File: rtl/pulse_envelope_controller.sv
// -----------------------------------------------------------------------------
// pulse_envelope_controller
// ADSR amplitude controller producing the 9-bit envelope level that gates the
// pulse channel's compare output. Note-on/note-off events come from the note
// sequencer; level changes happen only on envelope steps derived from the
// global tick strobe by envelope_tick_prescaler.
//
// Build option:
//   PULSE_ENVELOPE_HARD_RETRIGGER_EN  when defined, note-on restarts ATTACK
//                                     from level 0; otherwise ATTACK continues
//                                     from the current level (legato).
//
// Parameters:
//   LEVEL_MAX        peak envelope level (fits in 9 bits)
//   TICK_DIV         tick strobes per envelope step (1..255)
// Ports:
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_tick_stb       one-cycle envelope time-base strobe
//   i_note_on_stb    one-cycle note-start event
//   i_note_off_stb   one-cycle note-release event
//   i_attack_rate    level increment per ATTACK step (0 = instant)
//   i_decay_rate     level decrement per DECAY step (0 = instant)
//   i_sustain_level  SUSTAIN level, clamped to LEVEL_MAX
//   i_release_rate   level decrement per RELEASE step (0 = instant)
//   o_envelope       registered envelope level
//   o_active         registered, high in every state except IDLE
//   o_state          registered state encoding, for debug
// -----------------------------------------------------------------------------
module pulse_envelope_controller
  import pulse_envelope_pkg::*;
#(
  parameter int unsigned LEVEL_MAX = 511,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_tick_stb,
  input  logic                   i_note_on_stb,
  input  logic                   i_note_off_stb,
  input  logic [ENV_RATE_W-1:0]  i_attack_rate,
  input  logic [ENV_RATE_W-1:0]  i_decay_rate,
  input  logic [ENV_LEVEL_W-1:0] i_sustain_level,
  input  logic [ENV_RATE_W-1:0]  i_release_rate,
  output logic [ENV_LEVEL_W-1:0] o_envelope,
  output logic                   o_active,
  output logic [ENV_STATE_W-1:0] o_state
);

  localparam env_level_t LVL_MAX = env_level_t'(LEVEL_MAX);

  env_state_e state;
  env_level_t level;
  logic       active;

  logic       step_stb;
  logic       legal_state;
  logic       note_off_accepted;
  env_level_t sustain_clamped;
  env_level_t attack_next;
  env_level_t decay_next;
  env_level_t release_next;
  env_level_t retrigger_level;

  envelope_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_tick_stb (i_tick_stb),
    .i_restart  (i_note_on_stb),
    .o_step_stb (step_stb)
  );

  // ---------------------------------------------------------------------------
  // Level datapath: candidate next level for each stepping state.
  // ---------------------------------------------------------------------------
  assign sustain_clamped = (i_sustain_level > LVL_MAX) ? LVL_MAX : i_sustain_level;

  assign attack_next  = (i_attack_rate == '0) ? LVL_MAX
                      : sat_add(level, i_attack_rate, LVL_MAX);
  assign decay_next   = (i_decay_rate == '0) ? sustain_clamped
                      : sat_sub(level, i_decay_rate, sustain_clamped);
  assign release_next = (i_release_rate == '0) ? '0
                      : sat_sub(level, i_release_rate, '0);

`ifdef PULSE_ENVELOPE_HARD_RETRIGGER_EN
  assign retrigger_level = '0;
`else
  assign retrigger_level = level;
`endif

  assign legal_state = state inside {ENV_IDLE, ENV_ATTACK, ENV_DECAY,
                                     ENV_SUSTAIN, ENV_RELEASE};

  // Note-off only releases a sounding note; IDLE and RELEASE ignore it.
  assign note_off_accepted = i_note_off_stb &&
                             (state inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN});

  // ---------------------------------------------------------------------------
  // ADSR FSM and level register. Priority: illegal-state recovery, note-on,
  // note-off, then the step. An event in a step cycle therefore suppresses
  // that step's level change.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ENV_IDLE;
      level  <= '0;
      active <= 1'b0;
    end else if (!legal_state) begin
      state  <= ENV_IDLE;
      level  <= '0;
      active <= 1'b0;
    end else if (i_note_on_stb) begin
      state  <= ENV_ATTACK;
      level  <= retrigger_level;
      active <= 1'b1;
    end else if (note_off_accepted) begin
      state  <= ENV_RELEASE;
    end else if (step_stb) begin
      case (state)
        ENV_ATTACK: begin
          level <= attack_next;
          if (attack_next == LVL_MAX) state <= ENV_DECAY;
        end
        ENV_DECAY: begin
          level <= decay_next;
          if (decay_next == sustain_clamped) state <= ENV_SUSTAIN;
        end
        ENV_SUSTAIN: begin
          // Re-sampled every step so live sustain edits track promptly.
          level <= sustain_clamped;
        end
        ENV_RELEASE: begin
          level <= release_next;
          if (release_next == '0) begin
            state  <= ENV_IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          level <= '0;
        end
      endcase
    end
  end

  assign o_envelope = level;
  assign o_active   = active;
  assign o_state    = state;

endmodule : pulse_envelope_controller

// File: tb/tb_pulse_envelope_controller.sv
// -----------------------------------------------------------------------------
// tb_pulse_envelope_controller
// Two controllers (TICK_DIV = 1 and TICK_DIV = 4) share every input. A
// behavioural ADSR model tracks both and is compared with all outputs after
// each clock; directed steps add fixed expected values for the contour,
// instant-rate, prescaler, collision, retrigger and asynchronous-reset cases,
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_pulse_envelope_controller;

  localparam int LMAX      = 511;
  localparam int S_IDLE    = 0;
  localparam int S_ATTACK  = 1;
  localparam int S_DECAY   = 2;
  localparam int S_SUSTAIN = 3;
  localparam int S_RELEASE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick_stb = 1'b0;
  logic       note_on_stb = 1'b0;
  logic       note_off_stb = 1'b0;
  logic [7:0] attack_rate = '0;
  logic [7:0] decay_rate = '0;
  logic [8:0] sustain_level = '0;
  logic [7:0] release_rate = '0;

  logic [8:0] env1, env4;
  logic       act1, act4;
  logic [2:0] st1, st4;

  int checks = 0;
  int failures = 0;

  // Reference model state, index 0 = TICK_DIV 1, index 1 = TICK_DIV 4.
  int m_state [2];
  int m_lvl   [2];
  int m_pc    [2];
  int m_div   [2] = '{1, 4};

  always #5 clk = ~clk;

  pulse_envelope_controller #(.LEVEL_MAX(LMAX), .TICK_DIV(1)) u_dut1 (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_tick_stb      (tick_stb),
    .i_note_on_stb   (note_on_stb),
    .i_note_off_stb  (note_off_stb),
    .i_attack_rate   (attack_rate),
    .i_decay_rate    (decay_rate),
    .i_sustain_level (sustain_level),
    .i_release_rate  (release_rate),
    .o_envelope      (env1),
    .o_active        (act1),
    .o_state         (st1)
  );

  pulse_envelope_controller #(.LEVEL_MAX(LMAX), .TICK_DIV(4)) u_dut4 (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_tick_stb      (tick_stb),
    .i_note_on_stb   (note_on_stb),
    .i_note_off_stb  (note_off_stb),
    .i_attack_rate   (attack_rate),
    .i_decay_rate    (decay_rate),
    .i_sustain_level (sustain_level),
    .i_release_rate  (release_rate),
    .o_envelope      (env4),
    .o_active        (act4),
    .o_state         (st4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = S_IDLE;
      m_lvl[i]   = 0;
      m_pc[i]    = 0;
    end
  endtask

  // One clock edge of the ADSR rules, applied to both model instances.
  task automatic model_update(input bit on, input bit off, input bit tick);
    int sus;
    int nl;
    bit stp;
    sus = (int'(sustain_level) > LMAX) ? LMAX : int'(sustain_level);
    for (int i = 0; i < 2; i++) begin
      stp = 1'b0;
      if (on) m_pc[i] = 0;
      else if (tick) begin
        m_pc[i]++;
        if (m_pc[i] == m_div[i]) begin
          stp = 1'b1;
          m_pc[i] = 0;
        end
      end
      if (on) begin
        m_state[i] = S_ATTACK;
`ifdef PULSE_ENVELOPE_HARD_RETRIGGER_EN
        m_lvl[i] = 0;
`endif
      end else if (off && m_state[i] >= S_ATTACK && m_state[i] <= S_SUSTAIN) begin
        m_state[i] = S_RELEASE;
      end else if (stp) begin
        case (m_state[i])
          S_ATTACK: begin
            nl = (attack_rate == 0) ? LMAX : m_lvl[i] + int'(attack_rate);
            if (nl > LMAX) nl = LMAX;
            m_lvl[i] = nl;
            if (nl == LMAX) m_state[i] = S_DECAY;
          end
          S_DECAY: begin
            nl = (decay_rate == 0) ? sus : m_lvl[i] - int'(decay_rate);
            if (nl < sus) nl = sus;
            m_lvl[i] = nl;
            if (nl == sus) m_state[i] = S_SUSTAIN;
          end
          S_SUSTAIN: m_lvl[i] = sus;
          S_RELEASE: begin
            nl = (release_rate == 0) ? 0 : m_lvl[i] - int'(release_rate);
            if (nl < 0) nl = 0;
            m_lvl[i] = nl;
            if (nl == 0) m_state[i] = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_models(input string tag);
    check({tag, ".env1"},   32'(env1), 32'(m_lvl[0]));
    check({tag, ".state1"}, 32'(st1),  32'(m_state[0]));
    check({tag, ".act1"},   32'(act1), 32'(m_state[0] != S_IDLE));
    check({tag, ".env4"},   32'(env4), 32'(m_lvl[1]));
    check({tag, ".state4"}, 32'(st4),  32'(m_state[1]));
    check({tag, ".act4"},   32'(act4), 32'(m_state[1] != S_IDLE));
  endtask

  // Drive one cycle of strobes (from just after an edge), clock, then check.
  task automatic step(input bit on, input bit off, input bit tick, input string tag);
    note_on_stb  = on;
    note_off_stb = off;
    tick_stb     = tick;
    @(posedge clk);
    model_update(on, off, tick);
    #1;
    note_on_stb  = 1'b0;
    note_off_stb = 1'b0;
    tick_stb     = 1'b0;
    check_models(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, tag);
  endtask

  // Asserts reset between edges, checks outputs before any edge, releases
  // it just after the following edge.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_models(tag);
    check({tag, ".env1_zero"}, 32'(env1), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : main
    int contour [8] = '{128, 256, 384, 511, 447, 383, 319, 256};
    int exp_lvl;

    model_reset();
    #2;
    apply_reset("reset");

    // Basic contour at TICK_DIV 1
    attack_rate = 8'd128; decay_rate = 8'd64; sustain_level = 9'd256; release_rate = 8'd32;
    step(1'b1, 1'b0, 1'b0, "contour_on");
    check("contour_attack_state", 32'(st1), S_ATTACK);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, "contour_tick");
      check($sformatf("contour_env%0d", i), 32'(env1), 32'(contour[i]));
      if (i == 3) check("contour_decay_state", 32'(st1), S_DECAY);
    end
    check("contour_sustain_state", 32'(st1), S_SUSTAIN);
    step(1'b0, 1'b1, 1'b0, "contour_off");
    check("contour_release_state", 32'(st1), S_RELEASE);
    ticks(7, "contour_rel");
    check("contour_rel7_env", 32'(env1), 32'd32);
    ticks(1, "contour_rel");
    check("contour_end_env", 32'(env1), 32'd0);
    check("contour_end_state", 32'(st1), S_IDLE);
    check("contour_end_active", 32'(act1), 32'd0);

    // Instant rates
    attack_rate = 8'd0; decay_rate = 8'd0; sustain_level = 9'd100; release_rate = 8'd0;
    step(1'b1, 1'b0, 1'b0, "instant_on");
    ticks(1, "instant");
    check("instant_peak", 32'(env1), 32'd511);
    check("instant_peak_state", 32'(st1), S_DECAY);
    ticks(1, "instant");
    check("instant_sustain", 32'(env1), 32'd100);
    ticks(1, "instant");
    check("instant_hold", 32'(env1), 32'd100);
    check("instant_hold_state", 32'(st1), S_SUSTAIN);
    step(1'b0, 1'b1, 1'b0, "instant_off");
    ticks(1, "instant");
    check("instant_release_env", 32'(env1), 32'd0);
    check("instant_release_state", 32'(st1), S_IDLE);

    // Prescaler at TICK_DIV 4
    apply_reset("pre_reset");
    attack_rate = 8'd200; decay_rate = 8'd10; sustain_level = 9'd300;
    step(1'b1, 1'b0, 1'b0, "pre_on");
    ticks(3, "pre");
    check("pre_tick3", 32'(env4), 32'd0);
    ticks(1, "pre");
    check("pre_tick4", 32'(env4), 32'd200);
    ticks(4, "pre");
    check("pre_tick8", 32'(env4), 32'd400);
    ticks(4, "pre");
    check("pre_tick12", 32'(env4), 32'd511);
    check("pre_tick12_state", 32'(st4), S_DECAY);

    apply_reset("pre_reset2");
    step(1'b1, 1'b0, 1'b0, "pre2_on");
    ticks(5, "pre2");
    check("pre2_tick5", 32'(env4), 32'd200);
    step(1'b1, 1'b0, 1'b1, "pre2_retrig");
`ifdef PULSE_ENVELOPE_HARD_RETRIGGER_EN
    exp_lvl = 0;
`else
    exp_lvl = 200;
`endif
    ticks(3, "pre2");
    check("pre2_held", 32'(env4), 32'(exp_lvl));
    ticks(1, "pre2");
    check("pre2_step", 32'(env4), 32'(exp_lvl + 200));

    // Collisions
    apply_reset("col_reset");
    attack_rate = 8'd0; decay_rate = 8'd0; sustain_level = 9'd256;
    step(1'b1, 1'b0, 1'b0, "col_on");
    ticks(2, "col");
    check("col_sustain_state", 32'(st1), S_SUSTAIN);
    step(1'b1, 1'b1, 1'b0, "col_onoff");
    check("col_onoff_state", 32'(st1), S_ATTACK);

    apply_reset("col_reset2");
    attack_rate = 8'd100; release_rate = 8'd100;
    step(1'b1, 1'b0, 1'b0, "col2_on");
    ticks(3, "col2");
    check("col2_level", 32'(env1), 32'd300);
    step(1'b0, 1'b1, 1'b1, "col2_offstep");
    check("col2_state", 32'(st1), S_RELEASE);
    check("col2_env", 32'(env1), 32'd300);

    // Retrigger from RELEASE at level 200
    ticks(1, "retrig");
    check("retrig_release_env", 32'(env1), 32'd200);
    attack_rate = 8'd50;
    step(1'b1, 1'b0, 1'b0, "retrig_on");
    check("retrig_state", 32'(st1), S_ATTACK);
`ifdef PULSE_ENVELOPE_HARD_RETRIGGER_EN
    check("retrig_env", 32'(env1), 32'd0);
    ticks(1, "retrig");
    check("retrig_step", 32'(env1), 32'd50);
`else
    check("retrig_env", 32'(env1), 32'd200);
    ticks(1, "retrig");
    check("retrig_step", 32'(env1), 32'd250);
`endif

    // Asynchronous reset mid-DECAY
    apply_reset("mid_reset0");
    attack_rate = 8'd255; decay_rate = 8'd61; sustain_level = 9'd100;
    step(1'b1, 1'b0, 1'b0, "mid_on");
    ticks(4, "mid");
    check("mid_decay_env", 32'(env1), 32'd450);
    check("mid_decay_state", 32'(st1), S_DECAY);
    #3;
    apply_reset("mid_async");
    check("mid_async_state", 32'(st1), S_IDLE);
    check("mid_async_active", 32'(act1), 32'd0);
    step(1'b1, 1'b0, 1'b0, "mid_post_on");
    check("mid_post_state", 32'(st1), S_ATTACK);

    // Randomized run against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        attack_rate   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        decay_rate    = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        release_rate  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        sustain_level = 9'($urandom_range(0, 511));
      end
      step($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pulse_envelope_controller
